// File: rtl/alu_cmd_ctrl.sv
// Command-side ALU controller: one operation per in_valid/in_ready handshake,
// registered result and flags on an out_valid/out_ready channel, chained carry for ADC/SBB.
module alu_cmd_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_y,
  output logic         out_c,
  output logic         out_z,
  output logic         out_n,
  output logic         out_v,
  output logic         out_err
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t       state_q, state_d;
  logic [3:0]   op_q;
  logic [N-1:0] a_q, b_q;
  logic         carry_q;

  logic         is_add, is_sub, cin;
  logic [N-1:0] b_eff, y_d;
  logic [N:0]   sum;
  logic         c_d, v_d, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // SUB/SBB share the adder with an inverted B; SUB forces carry-in, ADC/SBB take carry_q
  always_comb begin
    is_add = (op_q == 4'h0) || (op_q == 4'h8);
    is_sub = (op_q == 4'h1) || (op_q == 4'h9);
    b_eff  = is_sub ? ~b_q : b_q;
    cin    = 1'b0;
    if (op_q == 4'h1)                        cin = 1'b1;
    else if (op_q == 4'h8 || op_q == 4'h9)   cin = carry_q;
    sum    = {1'b0, a_q} + {1'b0, b_eff} + {{N{1'b0}}, cin};
    y_d    = '0;
    c_d    = 1'b0;
    v_d    = 1'b0;
    err_d  = 1'b0;
    case (op_q)
      4'h0, 4'h1, 4'h8, 4'h9: begin
        y_d = sum[N-1:0];
        c_d = sum[N];
        v_d = (a_q[N-1] == b_eff[N-1]) && (sum[N-1] != a_q[N-1]);
      end
      4'h2:    y_d = a_q & b_q;
      4'h3:    y_d = a_q | b_q;
      4'h4:    y_d = ~(a_q & b_q);
      4'h5:    y_d = ~(a_q | b_q);
      4'h6:    y_d = a_q ^ b_q;
      4'h7:    y_d = ~(a_q ^ b_q);
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      out_y   <= '0;
      out_c   <= 1'b0;
      out_z   <= 1'b0;
      out_n   <= 1'b0;
      out_v   <= 1'b0;
      out_err <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        op_q <= in_op;
        a_q  <= in_a;
        b_q  <= in_b;
      end
      if (state_q == EXEC) begin
        out_y   <= y_d;
        out_c   <= c_d;
        out_z   <= (y_d == '0);
        out_n   <= y_d[N-1];
        out_v   <= v_d;
        out_err <= err_d;
        if (is_add || is_sub) carry_q <= c_d;
      end
    end
  end

endmodule
